// File: rtl/adc_frame_scheduler_if.sv
// adc_frame_scheduler_if: channel-FIFO side and frame-packer side signals of the ADC frame scheduler.
interface adc_frame_scheduler_if #(parameter int NCH = 16, DW = 16, CW = 4);
  logic enable;
  logic [3:0] sample_mode;
  logic [NCH-1:0] ch_req;
`ifdef ADC_SCHED_MASK_EN
  logic [NCH-1:0] ch_mask;
`endif
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0] ch_rd;
  logic [DW-1:0] data_out;
  logic data_valid;
  logic sync;
  logic [CW-1:0] cur_ch;
  logic busy;
  logic [15:0] frame_cnt;
`ifdef ADC_SCHED_MASK_EN
  modport master(input enable, sample_mode, ch_req, ch_mask, ch_data,
                 output ch_rd, data_out, data_valid, sync, cur_ch, busy, frame_cnt);
  modport slave(output enable, sample_mode, ch_req, ch_mask, ch_data,
                input ch_rd, data_out, data_valid, sync, cur_ch, busy, frame_cnt);
`else
  modport master(input enable, sample_mode, ch_req, ch_data,
                 output ch_rd, data_out, data_valid, sync, cur_ch, busy, frame_cnt);
  modport slave(output enable, sample_mode, ch_req, ch_data,
                input ch_rd, data_out, data_valid, sync, cur_ch, busy, frame_cnt);
`endif
endinterface

// File: rtl/adc_frame_scheduler.sv
// adc_frame_scheduler: round-robin frame scheduler sharing one ADC send path among NCH channels.
// Define ADC_SCHED_MASK_EN to add ch_mask gating of channel eligibility.
module adc_frame_scheduler #(
  parameter int NCH = 16,
  parameter int DW  = 16,
  parameter int CW  = 4,
  parameter int GAP = 2
)(
  input logic clk,
  input logic reset_n,
  adc_frame_scheduler_if.master bus
);
  localparam logic [2:0] IDLE = 3'd0, ARB = 3'd1, SEND = 3'd2, SYNC = 3'd3, WAIT = 3'd4;
  logic [2:0] state, nxt;
  logic [CW-1:0] last, gnt, rd_ch;
  logic [7:0] count, len_m1;
  logic [NCH-1:0] elig;
  logic found;
  always_comb begin
`ifdef ADC_SCHED_MASK_EN
    elig = bus.ch_req & bus.ch_mask;
`else
    elig = bus.ch_req;
`endif
    gnt = last;
    found = 1'b0;
    // descending scan so the nearest channel after last wins
    for (int k = NCH; k >= 1; k--) begin
      if (elig[(int'(last) + k) % NCH]) begin
        gnt = CW'((int'(last) + k) % NCH);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = bus.enable ? ARB : IDLE;
      ARB: nxt = !bus.enable ? IDLE : found ? SEND : ARB;
      SEND: nxt = count == len_m1 ? SYNC : SEND;
      SYNC: nxt = WAIT;
      WAIT: nxt = count == 8'(GAP - 1) ? (bus.enable ? ARB : IDLE) : WAIT;
      default: nxt = IDLE;
    endcase
  end
  assign rd_ch = state == ARB ? gnt : bus.cur_ch;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last <= CW'(NCH - 1);
      count <= '0;
      len_m1 <= '0;
      bus.ch_rd <= '0;
      bus.data_out <= '0;
      bus.data_valid <= 1'b0;
      bus.sync <= 1'b0;
      bus.cur_ch <= '0;
      bus.busy <= 1'b0;
      bus.frame_cnt <= '0;
    end else begin
      state <= nxt;
      count <= (nxt == state && (state == SEND || state == WAIT)) ? count + 8'd1 : 8'd0;
      bus.busy <= nxt != IDLE;
      bus.ch_rd <= nxt == SEND ? NCH'(1) << rd_ch : '0;
      bus.data_valid <= state == SEND;
      bus.sync <= state == SYNC;
      if (state == SEND) bus.data_out <= bus.ch_data[int'(bus.cur_ch) * DW +: DW];
      if (state == SYNC) bus.frame_cnt <= bus.frame_cnt + 16'd1;
      if (state == ARB && bus.enable && found) begin
        bus.cur_ch <= gnt;
        last <= gnt;
        len_m1 <= bus.sample_mode == 4'd0 ? 8'd15 : bus.sample_mode == 4'd1 ? 8'd31 : 8'd63;
      end
    end
  end
endmodule

// File: tb/tb_adc_frame_scheduler.sv
// tb_adc_frame_scheduler: randomized scoreboard bench for adc_frame_scheduler.
// Channel FIFOs are emulated with random per-channel word arrays indexed by read pointers.
module tb_adc_frame_scheduler;
  localparam int GAP = 2;
  typedef struct {int ch; int len; int fc; bit b2b;} frame_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  adc_frame_scheduler_if #(.NCH(16), .DW(16), .CW(4)) bus();
  adc_frame_scheduler #(.NCH(16), .DW(16), .CW(4), .GAP(GAP)) dut(.clk(clk), .reset_n(reset_n), .bus(bus.master));
  logic [15:0] mem [16][4096];
  logic [11:0] rp [16] = '{default: 12'd0};
  logic [11:0] mrp [16];
  frame_t fq[$];
  logic [15:0] dq[$];
  int nchk = 0, nerr = 0, nsync = 0, cyc = 0;
  int mlast = 15, mfc = 0;
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    for (int c = 0; c < 16; c++) if (bus.ch_rd[c]) rp[c] <= rp[c] + 12'd1;
  always_comb begin
    bus.ch_data = '0;
    for (int c = 0; c < 16; c++) bus.ch_data[c*16 +: 16] = mem[c][rp[c]];
  end
  task automatic check(input string name, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tmo(input string name);
    nchk++;
    nerr++;
    $display("FAIL %s: bound expired, got no event expected one", name);
  endtask
  // Monitor: accumulates strobes/data per frame and scores it at sync.
  initial begin
    int nrd = 0, nbad = 0, nval = 0, nde = 0, last_sync = 0;
    frame_t f;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        nrd = 0; nbad = 0; nval = 0; nde = 0;
      end else begin
        if (bus.ch_rd != 0) begin
          if (fq.size() != 0 && bus.ch_rd == 16'(1) << fq[0].ch) nrd++;
          else nbad++;
        end
        if (bus.data_valid) begin
          nval++;
          if (dq.size() == 0) nde++;
          else if (bus.data_out !== dq.pop_front()) nde++;
        end
        if (bus.sync) begin
          if (fq.size() == 0) check("unexpected_sync", 1, 0);
          else begin
            f = fq.pop_front();
            check("cur_ch", bus.cur_ch, f.ch);
            check("strobes", nrd, f.len);
            check("stray_rd", nbad, 0);
            check("valid_cnt", nval, f.len);
            check("data_err", nde, 0);
            check("frame_cnt", bus.frame_cnt, f.fc);
            if (f.b2b) check("sync_spacing", cyc - last_sync, f.len + GAP + 2);
          end
          last_sync = cyc;
          nsync++;
          nrd = 0; nbad = 0; nval = 0; nde = 0;
        end
      end
    end
  end
  function automatic logic [15:0] eligible(input logic [15:0] req, input logic [15:0] mask);
`ifdef ADC_SCHED_MASK_EN
    return req & mask;
`else
    return req | (mask & 16'h0);
`endif
  endfunction
  function automatic int pick(input logic [15:0] e);
    for (int k = 1; k <= 16; k++) if (e[(mlast + k) % 16]) return (mlast + k) % 16;
    return -1;
  endfunction
  task automatic drive(input logic [15:0] req, input logic [15:0] mask);
    bus.ch_req = req;
`ifdef ADC_SCHED_MASK_EN
    bus.ch_mask = mask;
`else
    if (mask == 16'hDEAD) bus.ch_req = req;
`endif
  endtask
  task automatic wait_rd(output bit ok);
    int t = 0;
    while (bus.ch_rd == 0 && t < 400) begin @(negedge clk); t++; end
    ok = bus.ch_rd != 0;
    if (!ok) tmo("frame_start");
  endtask
  // Runs n frames with req/mask/mode held; the last frame is interrupted by enable=0 and input churn.
  task automatic run_phase(input logic [15:0] req, input logic [15:0] mask, input logic [3:0] mode, input int n);
    int g, len, s, t;
    bit ok;
    frame_t f;
    len = mode == 0 ? 16 : mode == 1 ? 32 : 64;
    drive(req, mask);
    bus.sample_mode = mode;
    bus.enable = 1'b1;
    for (int i = 0; i < n; i++) begin
      g = pick(eligible(req, mask));
      if (g < 0) return;
      mlast = g;
      mfc = (mfc + 1) & 16'hFFFF;
      f.ch = g; f.len = len; f.fc = mfc; f.b2b = i > 0;
      fq.push_back(f);
      for (int j = 0; j < len; j++) dq.push_back(mem[g][12'(mrp[g] + 12'(j))]);
      mrp[g] = mrp[g] + 12'(len);
      s = nsync;
      if (i == n - 1) begin
        wait_rd(ok);
        repeat ($urandom_range(0, len - 2)) @(negedge clk);
        bus.enable = 1'b0;
        bus.sample_mode = 4'($urandom);
        drive(16'($urandom), 16'($urandom));
      end
      t = 0;
      while (nsync == s && t < 400) begin @(negedge clk); t++; end
      if (nsync == s) tmo("sync");
    end
    t = 0;
    while (bus.busy && t < 50) begin @(negedge clk); t++; end
    check("idle_busy", bus.busy, 0);
  endtask
  initial begin
    logic [15:0] r, m;
    bit ok;
    for (int c = 0; c < 16; c++) begin
      mrp[c] = 12'd0;
      for (int n = 0; n < 4096; n++) mem[c][n] = 16'($urandom);
    end
    bus.enable = 1'b0;
    bus.sample_mode = 4'd0;
    drive(16'h0, 16'hFFFF);
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.ch_rd, bus.data_out, bus.data_valid, bus.sync, bus.cur_ch, bus.busy, bus.frame_cnt}, 0);
    bus.enable = 1'b1;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("arb_busy", bus.busy, 1);
    check("arb_no_rd", bus.ch_rd, 0);
    check("arb_no_valid", bus.data_valid, 0);
    run_phase(16'hFFFF, 16'hFFFF, 4'd1, 17);
    run_phase(16'h0008, 16'hFFFF, 4'd0, 1);
    run_phase(16'h0008, 16'hFFFF, 4'd0, 3);
    for (int p = 0; p < 8; p++) begin
      r = 16'($urandom);
      m = 16'($urandom);
      r[$urandom_range(0, 15)] = 1'b1;
      m = m | r & ~(r - 16'd1);
`ifdef ADC_SCHED_MASK_EN
      m[$urandom_range(0, 15)] = 1'b0;
      m = m | r & ~(r - 16'd1);
`endif
      run_phase(r, m, 4'($urandom), $urandom_range(1, 4));
    end
`ifdef ADC_SCHED_MASK_EN
    run_phase(16'h000F, 16'h000A, 4'd0, 4);
`endif
    drive(16'h0080, 16'hFFFF);
    bus.sample_mode = 4'd0;
    bus.enable = 1'b1;
    wait_rd(ok);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midframe_reset", {bus.ch_rd, bus.data_out, bus.data_valid, bus.sync, bus.cur_ch, bus.busy, bus.frame_cnt}, 0);
    @(negedge clk);
    fq.delete();
    dq.delete();
    mlast = 15;
    mfc = 0;
    for (int c = 0; c < 16; c++) mrp[c] = rp[c];
    reset_n = 1'b1;
    run_phase(16'h0081, 16'hFFFF, 4'd0, 2);
    repeat (5) @(negedge clk);
    check("leftover_frames", fq.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
